lane_issue_ctrl: RTL and testbench

- Per-lane issue controller and scoreboard that sequences the parallel register-file plus multiplier datapath.
- Accepts one instruction per lane per cycle over valid/ready: MUL (rd = rs1*rs2) or LDI (rd = imm).
- Drives the register read ports, tracks in-flight multiplies through a MULT_LAT-deep writeback pipe, and drives the write port with w_sel selecting multiplier result vs immediate.
- Stalls on RAW/WAW hazards and on write-port conflicts. Each lane owns a private register bank; lanes never interact.

---
 rtl/lane_issue_ctrl_pkg.sv | 22 ++
 rtl/lane_issue_ctrl_if.sv | 37 +++
 rtl/lane_issue_ctrl_lane_sched.sv | 96 +++++++++
 rtl/lane_issue_ctrl.sv | 59 +++++
 tb/tb_lane_issue_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/lane_issue_ctrl_pkg.sv
// Shared types for the lane issue controller: opcode encoding, opcode decode
// helper and the latency limit.
package lane_issue_ctrl_pkg;

    localparam int MAX_MULT_LAT = 8;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_LDI = 2'd1,
        OP_MUL = 2'd2
    } op_e;

    // Encoding 3 is reserved and folds onto NOP.
    function automatic op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'd1:    return OP_LDI;
            2'd2:    return OP_MUL;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/lane_issue_ctrl_if.sv
// Instruction handshake plus register-file/multiplier control bundle shared
// by the issue controller (slave) and its instruction source (master).
interface lane_issue_ctrl_if #(
    parameter int LANES  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic [LANES-1:0]             in_valid;
    logic [LANES-1:0]             in_ready;
    logic [LANES-1:0][1:0]        in_op;
    logic [LANES-1:0][ADDR_W-1:0] in_rd;
    logic [LANES-1:0][ADDR_W-1:0] in_rs1;
    logic [LANES-1:0][ADDR_W-1:0] in_rs2;
    logic [LANES-1:0][DATA_W-1:0] in_imm;
    logic [LANES-1:0]             r_valid1;
    logic [LANES-1:0]             r_valid2;
    logic [LANES-1:0][ADDR_W-1:0] r_addr1;
    logic [LANES-1:0][ADDR_W-1:0] r_addr2;
    logic [LANES-1:0]             w_valid;
    logic [LANES-1:0]             w_sel;
    logic [LANES-1:0][ADDR_W-1:0] w_addr;
    logic [LANES-1:0][DATA_W-1:0] w_data;
    logic [LANES-1:0]             busy;
    logic                         idle;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready, r_valid1, r_valid2, r_addr1, r_addr2,
        input  w_valid, w_sel, w_addr, w_data, busy, idle
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready, r_valid1, r_valid2, r_addr1, r_addr2,
        output w_valid, w_sel, w_addr, w_data, busy, idle
    );
endinterface

// File: rtl/lane_issue_ctrl_lane_sched.sv
// One lane: register scoreboard, MUL writeback shift pipe, hazard detection
// and read/write port muxing.
module lane_sched
    import lane_issue_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 16,
    parameter int MULT_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [1:0]        in_op_i,
    input  logic [ADDR_W-1:0] in_rd_i,
    input  logic [ADDR_W-1:0] in_rs1_i,
    input  logic [ADDR_W-1:0] in_rs2_i,
    input  logic [DATA_W-1:0] in_imm_i,
    output logic              r_valid1_o,
    output logic              r_valid2_o,
    output logic [ADDR_W-1:0] r_addr1_o,
    output logic [ADDR_W-1:0] r_addr2_o,
    output logic              w_valid_o,
    output logic              w_sel_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [DATA_W-1:0] w_data_o,
    output logic              busy_o
);
    localparam int NREG = 2 ** ADDR_W;

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] rd;
    } pipe_ent_t;

    op_e                          op;
    logic [NREG-1:0]              sb_q, sb_d;
    pipe_ent_t [MULT_LAT-1:0]     pipe_q, pipe_d;
    logic                         wb_v;
    logic [ADDR_W-1:0]            wb_rd;
    logic                         hazard;
    logic                         go_mul, go_ldi;

    assign op    = decode_op(in_op_i);
    assign wb_v  = pipe_q[MULT_LAT-1].v;
    assign wb_rd = pipe_q[MULT_LAT-1].rd;

    // LDI uses the write port in its accept cycle, so any writeback blocks it.
    always_comb begin
        hazard = 1'b0;
        case (op)
            OP_MUL:  hazard = sb_q[in_rs1_i] | sb_q[in_rs2_i] | sb_q[in_rd_i];
            OP_LDI:  hazard = sb_q[in_rd_i] | wb_v;
            default: hazard = 1'b0;
        endcase
    end

    assign in_ready_o = ~hazard;
    // rst_n gating keeps all issue outputs quiet while reset is held.
    assign go_mul = rst_n & in_valid_i & ~hazard & (op == OP_MUL);
    assign go_ldi = rst_n & in_valid_i & ~hazard & (op == OP_LDI);

    assign r_valid1_o = go_mul;
    assign r_valid2_o = go_mul;
    assign r_addr1_o  = go_mul ? in_rs1_i : '0;
    assign r_addr2_o  = go_mul ? in_rs2_i : '0;
    assign w_valid_o  = wb_v | go_ldi;
    assign w_sel_o    = wb_v;
    assign w_addr_o   = wb_v ? wb_rd : (go_ldi ? in_rd_i : '0);
    assign w_data_o   = go_ldi ? in_imm_i : '0;

    always_comb begin
        busy_o = 1'b0;
        for (int s = 0; s < MULT_LAT; s++) busy_o = busy_o | pipe_q[s].v;
    end

    always_comb begin
        pipe_d[0].v  = go_mul;
        pipe_d[0].rd = go_mul ? in_rd_i : '0;
        for (int s = 1; s < MULT_LAT; s++) pipe_d[s] = pipe_q[s-1];
        sb_d = sb_q;
        if (wb_v)   sb_d[wb_rd]   = 1'b0;
        if (go_mul) sb_d[in_rd_i] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q   <= '0;
            pipe_q <= '0;
        end else begin
            sb_q   <= sb_d;
            pipe_q <= pipe_d;
        end
    end

endmodule

// File: rtl/lane_issue_ctrl.sv
// Per-lane issue controller top: replicates the lane scheduler and reduces
// the per-lane busy flags into a global idle.
module lane_issue_ctrl
    import lane_issue_ctrl_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 16,
    parameter int MULT_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    lane_issue_ctrl_if.slave  bus
);
    logic [LANES-1:0]             in_ready;
    logic [LANES-1:0]             r_valid1, r_valid2, w_valid, w_sel, busy;
    logic [LANES-1:0][ADDR_W-1:0] r_addr1, r_addr2, w_addr;
    logic [LANES-1:0][DATA_W-1:0] w_data;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_sched #(
            .ADDR_W   (ADDR_W),
            .DATA_W   (DATA_W),
            .MULT_LAT (MULT_LAT)
        ) u_sched (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid_i (bus.in_valid[g]),
            .in_ready_o (in_ready[g]),
            .in_op_i    (bus.in_op[g]),
            .in_rd_i    (bus.in_rd[g]),
            .in_rs1_i   (bus.in_rs1[g]),
            .in_rs2_i   (bus.in_rs2[g]),
            .in_imm_i   (bus.in_imm[g]),
            .r_valid1_o (r_valid1[g]),
            .r_valid2_o (r_valid2[g]),
            .r_addr1_o  (r_addr1[g]),
            .r_addr2_o  (r_addr2[g]),
            .w_valid_o  (w_valid[g]),
            .w_sel_o    (w_sel[g]),
            .w_addr_o   (w_addr[g]),
            .w_data_o   (w_data[g]),
            .busy_o     (busy[g])
        );
    end

    assign bus.in_ready = in_ready;
    assign bus.r_valid1 = r_valid1;
    assign bus.r_valid2 = r_valid2;
    assign bus.r_addr1  = r_addr1;
    assign bus.r_addr2  = r_addr2;
    assign bus.w_valid  = w_valid;
    assign bus.w_sel    = w_sel;
    assign bus.w_addr   = w_addr;
    assign bus.w_data   = w_data;
    assign bus.busy     = busy;
    assign bus.idle     = ~|busy;

endmodule

// File: tb/tb_lane_issue_ctrl.sv
// Directed bench for lane_issue_ctrl with MULT_LAT=2: LDI, MUL latency,
// RAW/WAW stalls, write-port conflict, streaming and mid-flight reset.
module tb_lane_issue_ctrl;
    localparam int LANES = 4, ADDR_W = 5, DATA_W = 16, MULT_LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   nchk  = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    lane_issue_ctrl_if #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lane_issue_ctrl #(
        .LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MULT_LAT(MULT_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic drive(input int l, input logic [1:0] op, input int rd,
                         input int rs1, input int rs2, input logic [15:0] imm);
        bus.in_valid[l] = 1'b1;
        bus.in_op[l]    = op;
        bus.in_rd[l]    = ADDR_W'(rd);
        bus.in_rs1[l]   = ADDR_W'(rs1);
        bus.in_rs2[l]   = ADDR_W'(rs2);
        bus.in_imm[l]   = imm;
    endtask

    task automatic clear_lane(input int l);
        bus.in_valid[l] = 1'b0;
        bus.in_op[l]    = 2'd0;
        bus.in_rd[l]    = '0;
        bus.in_rs1[l]   = '0;
        bus.in_rs2[l]   = '0;
        bus.in_imm[l]   = '0;
    endtask

    task automatic clear_all();
        for (int l = 0; l < LANES; l++) clear_lane(l);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_all();
        drive(0, 2'd1, 3, 0, 0, 16'h1111);
        #1;
        nchk++; if (bus.in_ready !== 4'hF) begin nfail++; $display("FAIL rst_in_ready actual=%h expected=f", bus.in_ready); end
        nchk++; if (bus.idle !== 1'b1) begin nfail++; $display("FAIL rst_idle actual=%b expected=1", bus.idle); end
        nchk++; if (bus.w_valid !== 4'h0) begin nfail++; $display("FAIL rst_w_valid actual=%h expected=0", bus.w_valid); end
        nchk++; if (bus.w_data[0] !== 16'h0) begin nfail++; $display("FAIL rst_w_data actual=%h expected=0", bus.w_data[0]); end
        nchk++; if (bus.busy !== 4'h0) begin nfail++; $display("FAIL rst_busy actual=%h expected=0", bus.busy); end
        repeat (2) @(negedge clk);
        clear_all();
        rst_n = 1'b1;
    endtask

    task automatic test_ldi();
        @(negedge clk); drive(0, 2'd1, 3, 0, 0, 16'h00A5); #1;
        nchk++; if (bus.w_valid[0] !== 1'b1) begin nfail++; $display("FAIL ldi_w_valid actual=%b expected=1", bus.w_valid[0]); end
        nchk++; if (bus.w_sel[0] !== 1'b0) begin nfail++; $display("FAIL ldi_w_sel actual=%b expected=0", bus.w_sel[0]); end
        nchk++; if (bus.w_addr[0] !== 5'd3) begin nfail++; $display("FAIL ldi_w_addr actual=%0d expected=3", bus.w_addr[0]); end
        nchk++; if (bus.w_data[0] !== 16'h00A5) begin nfail++; $display("FAIL ldi_w_data actual=%h expected=00a5", bus.w_data[0]); end
        nchk++; if (bus.r_valid1[0] !== 1'b0) begin nfail++; $display("FAIL ldi_r_valid1 actual=%b expected=0", bus.r_valid1[0]); end
        @(negedge clk); clear_lane(0); #1;
        nchk++; if ({bus.w_valid[0], bus.w_sel[0], bus.w_addr[0], bus.w_data[0]} !== 23'h0) begin nfail++;
            $display("FAIL ldi_after actual=%b/%b/%0d/%h expected=0/0/0/0", bus.w_valid[0], bus.w_sel[0], bus.w_addr[0], bus.w_data[0]); end
    endtask

    task automatic test_mul();
        @(negedge clk); drive(0, 2'd2, 4, 1, 2, 16'h0); #1;
        nchk++; if ({bus.r_valid1[0], bus.r_valid2[0]} !== 2'b11) begin nfail++; $display("FAIL mul_r_valid actual=%b%b expected=11", bus.r_valid1[0], bus.r_valid2[0]); end
        nchk++; if (bus.r_addr1[0] !== 5'd1 || bus.r_addr2[0] !== 5'd2) begin nfail++; $display("FAIL mul_r_addr actual=%0d,%0d expected=1,2", bus.r_addr1[0], bus.r_addr2[0]); end
        nchk++; if (bus.busy[0] !== 1'b0) begin nfail++; $display("FAIL mul_busy_t0 actual=%b expected=0", bus.busy[0]); end
        @(negedge clk); clear_lane(0); #1;
        nchk++; if (bus.busy[0] !== 1'b1 || bus.idle !== 1'b0) begin nfail++; $display("FAIL mul_busy_t1 actual=%b/%b expected=1/0", bus.busy[0], bus.idle); end
        nchk++; if (bus.w_valid[0] !== 1'b0 || bus.r_valid1[0] !== 1'b0) begin nfail++; $display("FAIL mul_quiet_t1 actual=%b/%b expected=0/0", bus.w_valid[0], bus.r_valid1[0]); end
        @(negedge clk); #1;
        nchk++; if ({bus.w_valid[0], bus.w_sel[0]} !== 2'b11 || bus.w_addr[0] !== 5'd4 || bus.w_data[0] !== 16'h0) begin nfail++;
            $display("FAIL mul_wb actual=%b/%b/%0d/%h expected=1/1/4/0", bus.w_valid[0], bus.w_sel[0], bus.w_addr[0], bus.w_data[0]); end
        nchk++; if (bus.busy[0] !== 1'b1) begin nfail++; $display("FAIL mul_busy_t2 actual=%b expected=1", bus.busy[0]); end
        @(negedge clk); #1;
        nchk++; if (bus.busy[0] !== 1'b0 || bus.idle !== 1'b1 || bus.w_valid[0] !== 1'b0) begin nfail++;
            $display("FAIL mul_done actual=%b/%b/%b expected=0/1/0", bus.busy[0], bus.idle, bus.w_valid[0]); end
    endtask

    task automatic test_raw();
        @(negedge clk); drive(0, 2'd2, 4, 1, 2, 16'h0); #1;
        nchk++; if (bus.in_ready[0] !== 1'b1) begin nfail++; $display("FAIL raw_first_ready actual=%b expected=1", bus.in_ready[0]); end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk); drive(0, 2'd2, 5, 4, 4, 16'h0); #1;
            nchk++; if (bus.in_ready[0] !== 1'b0 || bus.r_valid1[0] !== 1'b0) begin nfail++;
                $display("FAIL raw_stall_c%0d actual=%b/%b expected=0/0", c, bus.in_ready[0], bus.r_valid1[0]); end
        end
        @(negedge clk); #1;
        nchk++; if (bus.in_ready[0] !== 1'b1 || bus.r_valid1[0] !== 1'b1 || bus.r_addr1[0] !== 5'd4) begin nfail++;
            $display("FAIL raw_accept actual=%b/%b/%0d expected=1/1/4", bus.in_ready[0], bus.r_valid1[0], bus.r_addr1[0]); end
        @(negedge clk); clear_lane(0); #1;
        nchk++; if (bus.w_valid[0] !== 1'b0) begin nfail++; $display("FAIL raw_gap actual=%b expected=0", bus.w_valid[0]); end
        @(negedge clk); #1;
        nchk++; if (bus.w_valid[0] !== 1'b1 || bus.w_sel[0] !== 1'b1 || bus.w_addr[0] !== 5'd5) begin nfail++;
            $display("FAIL raw_wb actual=%b/%b/%0d expected=1/1/5", bus.w_valid[0], bus.w_sel[0], bus.w_addr[0]); end
        @(negedge clk); #1;
    endtask

    task automatic test_waw();
        @(negedge clk); drive(1, 2'd2, 9, 1, 2, 16'h0); #1;
        @(negedge clk); drive(1, 2'd1, 9, 0, 0, 16'hBEEF); #1;
        nchk++; if (bus.in_ready[1] !== 1'b0 || bus.w_valid[1] !== 1'b0) begin nfail++;
            $display("FAIL waw_stall actual=%b/%b expected=0/0", bus.in_ready[1], bus.w_valid[1]); end
        @(negedge clk); #1;
        nchk++; if (bus.in_ready[1] !== 1'b0 || bus.w_sel[1] !== 1'b1 || bus.w_addr[1] !== 5'd9) begin nfail++;
            $display("FAIL waw_wb actual=%b/%b/%0d expected=0/1/9", bus.in_ready[1], bus.w_sel[1], bus.w_addr[1]); end
        @(negedge clk); #1;
        nchk++; if (bus.in_ready[1] !== 1'b1 || bus.w_sel[1] !== 1'b0 || bus.w_data[1] !== 16'hBEEF) begin nfail++;
            $display("FAIL waw_ldi actual=%b/%b/%h expected=1/0/beef", bus.in_ready[1], bus.w_sel[1], bus.w_data[1]); end
        @(negedge clk); clear_lane(1); #1;
    endtask

    task automatic test_reserved();
        @(negedge clk); drive(2, 2'd3, 5, 6, 7, 16'h5555); #1;
        nchk++; if (bus.in_ready[2] !== 1'b1 || bus.r_valid1[2] !== 1'b0 || bus.w_valid[2] !== 1'b0 || bus.r_addr1[2] !== 5'd0) begin nfail++;
            $display("FAIL rsvd_issue actual=%b/%b/%b/%0d expected=1/0/0/0", bus.in_ready[2], bus.r_valid1[2], bus.w_valid[2], bus.r_addr1[2]); end
        @(negedge clk); clear_lane(2); #1;
        nchk++; if (bus.busy[2] !== 1'b0) begin nfail++; $display("FAIL rsvd_busy actual=%b expected=0", bus.busy[2]); end
    endtask

    task automatic test_write_conflict();
        @(negedge clk); drive(0, 2'd2, 6, 1, 2, 16'h0); #1;
        @(negedge clk); clear_lane(0); #1;
        @(negedge clk); drive(0, 2'd1, 7, 0, 0, 16'h1234); drive(1, 2'd1, 7, 0, 0, 16'h4321); #1;
        nchk++; if (bus.in_ready[0] !== 1'b0) begin nfail++; $display("FAIL wc_stall actual=%b expected=0", bus.in_ready[0]); end
        nchk++; if (bus.w_sel[0] !== 1'b1 || bus.w_addr[0] !== 5'd6 || bus.w_data[0] !== 16'h0) begin nfail++;
            $display("FAIL wc_wb actual=%b/%0d/%h expected=1/6/0", bus.w_sel[0], bus.w_addr[0], bus.w_data[0]); end
        nchk++; if (bus.in_ready[1] !== 1'b1 || bus.w_data[1] !== 16'h4321) begin nfail++;
            $display("FAIL wc_other_lane actual=%b/%h expected=1/4321", bus.in_ready[1], bus.w_data[1]); end
        @(negedge clk); clear_lane(1); #1;
        nchk++; if (bus.in_ready[0] !== 1'b1 || bus.w_valid[0] !== 1'b1 || bus.w_sel[0] !== 1'b0 || bus.w_addr[0] !== 5'd7 || bus.w_data[0] !== 16'h1234) begin nfail++;
            $display("FAIL wc_ldi actual=%b/%b/%b/%0d/%h expected=1/1/0/7/1234", bus.in_ready[0], bus.w_valid[0], bus.w_sel[0], bus.w_addr[0], bus.w_data[0]); end
        @(negedge clk); clear_lane(0); #1;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c < 4) drive(0, 2'd2, 8 + c, 1, 2, 16'h0); else clear_lane(0);
            #1;
            if (c < 4) begin
                nchk++; if (bus.in_ready[0] !== 1'b1 || bus.r_valid1[0] !== 1'b1) begin nfail++;
                    $display("FAIL b2b_issue_c%0d actual=%b/%b expected=1/1", c, bus.in_ready[0], bus.r_valid1[0]); end
            end
            if (c >= 2 && c <= 5) begin
                nchk++; if (bus.w_valid[0] !== 1'b1 || bus.w_sel[0] !== 1'b1 || bus.w_addr[0] !== ADDR_W'(8 + c - 2)) begin nfail++;
                    $display("FAIL b2b_wb_c%0d actual=%b/%b/%0d expected=1/1/%0d", c, bus.w_valid[0], bus.w_sel[0], bus.w_addr[0], 8 + c - 2); end
            end
            if (c == 6) begin
                nchk++; if (bus.idle !== 1'b1 || bus.w_valid[0] !== 1'b0) begin nfail++;
                    $display("FAIL b2b_idle actual=%b/%b expected=1/0", bus.idle, bus.w_valid[0]); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk); drive(0, 2'd2, 12, 1, 2, 16'h0); #1;
        @(negedge clk); drive(0, 2'd2, 13, 1, 2, 16'h0); #1;
        @(negedge clk); clear_lane(0); #1;
        nchk++; if (bus.w_valid[0] !== 1'b1 || bus.w_addr[0] !== 5'd12) begin nfail++;
            $display("FAIL mrst_pre_wb actual=%b/%0d expected=1/12", bus.w_valid[0], bus.w_addr[0]); end
        #1 rst_n = 1'b0;
        #1;
        nchk++; if (bus.w_valid !== 4'h0 || bus.busy !== 4'h0 || bus.idle !== 1'b1 || bus.w_addr[0] !== 5'd0) begin nfail++;
            $display("FAIL mrst_async actual=%h/%h/%b/%0d expected=0/0/1/0", bus.w_valid, bus.busy, bus.idle, bus.w_addr[0]); end
        @(negedge clk); rst_n = 1'b1; drive(0, 2'd2, 14, 12, 13, 16'h0); #1;
        nchk++; if (bus.in_ready[0] !== 1'b1 || bus.r_valid1[0] !== 1'b1 || bus.w_valid[0] !== 1'b0) begin nfail++;
            $display("FAIL mrst_issue actual=%b/%b/%b expected=1/1/0", bus.in_ready[0], bus.r_valid1[0], bus.w_valid[0]); end
        @(negedge clk); clear_lane(0); #1;
        nchk++; if (bus.w_valid[0] !== 1'b0) begin nfail++; $display("FAIL mrst_no_stale_wb actual=%b expected=0", bus.w_valid[0]); end
        @(negedge clk); #1;
        nchk++; if (bus.w_valid[0] !== 1'b1 || bus.w_addr[0] !== 5'd14) begin nfail++;
            $display("FAIL mrst_wb actual=%b/%0d expected=1/14", bus.w_valid[0], bus.w_addr[0]); end
        @(negedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_mul();
        test_raw();
        test_waw();
        test_reserved();
        test_write_conflict();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
